// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - byte-stream command decoder that loads imem/dmem words and starts/halts the cpu
// Optional LOADER_CHECKSUM_EN: one trailing XOR check byte per non-empty load.
module cpu_program_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic [63:0] dmem_wdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_PAYLOAD, S_WRITE, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_PAYLOAD, S_WRITE} state_t;
`endif

    localparam logic [15:0] IMEM_N = 16'(IMEM_DEPTH);
    localparam logic [15:0] DMEM_N = 16'(DMEM_DEPTH);

    state_t      r_state;
    logic        r_is_dmem;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [2:0]  r_byte_idx;
    logic [63:0] r_asm;
    logic        r_in_ready;
    logic [63:0] r_imem_addr;
    logic        r_imem_wen;
    logic [31:0] r_imem_wdata;
    logic [63:0] r_dmem_addr;
    logic        r_dmem_wen;
    logic [63:0] r_dmem_wdata;
    logic        r_cpu_enable;
    logic        r_busy;
    logic        r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_over;
    logic        w_last_byte;
    logic [15:0] w_word_next;
    logic [63:0] w_asm_next;

    assign w_accept    = in_valid & r_in_ready;
    assign w_len       = {in_data, r_len_lo};
    assign w_over      = r_is_dmem ? (w_len > DMEM_N) : (w_len > IMEM_N);
    assign w_last_byte = r_is_dmem ? (r_byte_idx == 3'd7) : (r_byte_idx == 3'd3);
    assign w_word_next = r_word_idx + 16'd1;

    // Word as it will look once the byte on the bus lands, so WRITE can present it directly.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_byte_idx, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_dmem    <= 1'b0;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_idx   <= 16'd0;
            r_byte_idx   <= 3'd0;
            r_asm        <= 64'd0;
            r_in_ready   <= 1'b1;
            r_imem_addr  <= 64'd0;
            r_imem_wen   <= 1'b0;
            r_imem_wdata <= 32'd0;
            r_dmem_addr  <= 64'd0;
            r_dmem_wen   <= 1'b0;
            r_dmem_wdata <= 64'd0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    case (in_data)
                        8'hA5, 8'h5A: begin
                            if (r_cpu_enable) begin
                                r_err <= 1'b1;
                            end else begin
                                r_is_dmem <= (in_data == 8'h5A);
                                r_state   <= S_LEN0;
                                r_busy    <= 1'b1;
                            end
                        end
                        8'h0F:   r_cpu_enable <= 1'b1;
                        8'hF0:   r_cpu_enable <= 1'b0;
                        8'hEE:   r_err        <= 1'b0;
                        default: r_err        <= 1'b1;
                    endcase
                end
                S_LEN0: if (w_accept) begin
                    r_len_lo <= in_data;
                    r_state  <= S_LEN1;
                end
                S_LEN1: if (w_accept) begin
                    r_len      <= w_len;
                    r_word_idx <= 16'd0;
                    r_byte_idx <= 3'd0;
`ifdef LOADER_CHECKSUM_EN
                    r_xor      <= 8'd0;
`endif
                    if (w_len == 16'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_over) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (w_accept) begin
                    r_asm <= w_asm_next;
`ifdef LOADER_CHECKSUM_EN
                    r_xor <= r_xor ^ in_data;
`endif
                    if (w_last_byte) begin
                        r_byte_idx <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_WRITE;
                        if (r_is_dmem) begin
                            r_dmem_wen   <= 1'b1;
                            r_dmem_addr  <= {45'd0, r_word_idx, 3'b000};
                            r_dmem_wdata <= w_asm_next;
                        end else begin
                            r_imem_wen   <= 1'b1;
                            r_imem_addr  <= {46'd0, r_word_idx, 2'b00};
                            r_imem_wdata <= w_asm_next[31:0];
                        end
                    end else begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                    end
                end
                S_WRITE: begin
                    r_imem_wen <= 1'b0;
                    r_dmem_wen <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_word_idx <= w_word_next;
                    if (w_word_next == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHK;
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_state <= S_PAYLOAD;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: if (w_accept) begin
                    if (in_data != r_xor) r_err <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_addr  = r_imem_addr;
    assign imem_wen   = r_imem_wen;
    assign imem_wdata = r_imem_wdata;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wen   = r_dmem_wen;
    assign dmem_wdata = r_dmem_wdata;
    assign cpu_enable = r_cpu_enable;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb/tb_cpu_program_loader.sv - scoreboard bench for cpu_program_loader with a packet-level reference model
module tb_cpu_program_loader;

    localparam int IMEM_DEPTH = 512;
    localparam int DMEM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic [63:0] imem_addr;
    logic        imem_wen;
    logic [31:0] imem_wdata;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic        cpu_enable;
    logic        busy;
    logic        err;

    cpu_program_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .cpu_enable(cpu_enable), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_dmem;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pl[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         m_en = 1'b0;
    bit         m_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the next expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_wen || dmem_wen) begin
                wr_t e;
                chk("wen_exclusive", 64'(imem_wen & dmem_wen), 64'd0);
                chk("in_ready_in_write", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got imem_wen=%0b dmem_wen=%0b expected none", imem_wen, dmem_wen);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_kind", 64'(dmem_wen), 64'(e.is_dmem));
                    if (e.is_dmem) begin
                        chk("dmem_addr", dmem_addr, e.addr);
                        chk("dmem_wdata", dmem_wdata, e.data);
                    end else begin
                        chk("imem_addr", imem_addr, e.addr);
                        chk("imem_wdata", 64'(imem_wdata), e.data);
                    end
                end
            end else begin
                chk("in_ready_outside_write", 64'(in_ready), 64'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 100) begin @(posedge clk); #1; t++; end
        chk("busy_returns_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_status(input string nm);
        chk({nm, "_err"}, 64'(err), 64'(m_err));
        chk({nm, "_cpu_enable"}, 64'(cpu_enable), 64'(m_en));
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_cmd(input logic [7:0] b);
        send_byte(b, 0);
        case (b)
            8'h0F: m_en = 1'b1;
            8'hF0: m_en = 1'b0;
            8'hEE: m_err = 1'b0;
            default: m_err = 1'b1;
        endcase
        check_status("cmd");
    endtask

    task automatic fill_random(input int count);
        pl.delete();
        for (int i = 0; i < count; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    // Payload comes from pl[]; gap_at/gap_len insert one stall before that payload byte,
    // rnd adds random stalls anywhere in the packet.
    task automatic do_load(input bit d, input int n, input int gap_at, input int gap_len,
                           input bit rnd, input bit bad_chk);
        int bpw;
        int depth;
        logic [7:0] x;
        bpw   = d ? 8 : 4;
        depth = d ? DMEM_DEPTH : IMEM_DEPTH;
        send_byte(d ? 8'h5A : 8'hA5, 0);
        if (m_en) begin
            m_err = 1'b1;
            check_status("load_while_running");
            return;
        end
        send_byte(8'(n), rnd && $urandom_range(0, 3) == 0 ? 2 : 0);
        send_byte(8'(n >> 8), rnd && $urandom_range(0, 3) == 0 ? 2 : 0);
        if (n > depth) begin
            m_err = 1'b1;
        end else if (n > 0) begin
            x = 8'd0;
            for (int w = 0; w < n; w++) begin
                wr_t e;
                e.is_dmem = d;
                e.addr    = 64'(w * bpw);
                e.data    = 64'd0;
                for (int k = 0; k < bpw; k++) e.data = e.data | (64'(pl[w*bpw+k]) << (8*k));
                exp_q.push_back(e);
            end
            for (int i = 0; i < n * bpw; i++) begin
                int g;
                g = (i == gap_at) ? gap_len : 0;
                if (rnd && $urandom_range(0, 4) == 0) g = g + $urandom_range(1, 3);
                send_byte(pl[i], g);
                x = x ^ pl[i];
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_chk ? (x ^ 8'h01) : x, 0);
            if (bad_chk) m_err = 1'b1;
`endif
        end
        wait_idle();
        check_status("load");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_dmem_wdata", dmem_wdata, 64'd0);
        chk("rst_wen", 64'({imem_wen, dmem_wen}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_load(1'b0, 2, -1, 0, 1'b0, 1'b0);

        pl = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        do_load(1'b1, 1, 4, 3, 1'b0, 1'b0);

        do_cmd(8'h0F);
        do_load(1'b0, 1, -1, 0, 1'b0, 1'b0);
        do_cmd(8'hF0);
        do_cmd(8'hEE);
        do_cmd(8'h7B);
        do_cmd(8'hEE);

        fill_random(IMEM_DEPTH * 4);
        do_load(1'b0, IMEM_DEPTH, -1, 0, 1'b0, 1'b0);
        do_load(1'b0, IMEM_DEPTH + 1, -1, 0, 1'b0, 1'b0);
        do_cmd(8'hEE);
        do_load(1'b1, 0, -1, 0, 1'b0, 1'b0);

        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_en = 1'b0;
        m_err = 1'b0;
        check_status("mid_reset");
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(1'b0, 1, -1, 0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        pl = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_load(1'b0, 1, -1, 0, 1'b0, 1'b0);
        do_load(1'b0, 1, -1, 0, 1'b0, 1'b1);
        do_cmd(8'hEE);
`endif

        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                logic [7:0] c;
                case ($urandom_range(0, 3))
                    0: c = 8'h0F;
                    1: c = 8'hF0;
                    2: c = 8'hEE;
                    default: begin
                        c = 8'($urandom_range(0, 255));
                        while (c == 8'hA5 || c == 8'h5A || c == 8'h0F || c == 8'hF0 || c == 8'hEE)
                            c = 8'($urandom_range(0, 255));
                    end
                endcase
                do_cmd(c);
            end else begin
                bit d;
                int n;
                d = 1'($urandom_range(0, 1));
                n = (kind == 9) ? (d ? DMEM_DEPTH + 1 : IMEM_DEPTH + 1) : $urandom_range(0, 5);
                fill_random((n <= 8) ? n * 8 : 0);
                do_load(d, n, -1, 0, 1'b1, 1'($urandom_range(0, 3) == 0));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Upstream of the cpu top; drives its external memory ports (addr_ext/wen_ext/wdata_ext and addr_ext_2/wen_ext_2/wdata_ext_2) and its enable input.
- Accepts a byte stream with a valid/ready handshake.
- Decodes a small command protocol, assembles little-endian 32-bit instruction words and 64-bit data words, and writes them into instruction or data memory.
- Starts or halts the processor on command.

Parameters:
- IMEM_DEPTH, 512, instruction memory capacity in 32-bit words.
- DMEM_DEPTH, 1024, data memory capacity in 64-bit words.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset; synchronous, active-high. All state is cleared on the rising edge of clk while rst=1.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid & in_ready.
- imem_addr  out  64  instruction memory byte address (to addr_ext).
- imem_wen  out  1  instruction memory write strobe (to wen_ext).
- imem_wdata  out  32  instruction word (to wdata_ext).
- dmem_addr  out  64  data memory byte address (to addr_ext_2).
- dmem_wen  out  1  data memory write strobe (to wen_ext_2).
- dmem_wdata  out  64  data word (to wdata_ext_2).
- cpu_enable  out  1  drives cpu enable.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag; cleared only by rst or by a CLR command.

Behaviour:
- Reset values: all outputs 0, except in_ready=1. State is IDLE. Byte counter, word counter and assembly registers are 0.
- Command bytes, decoded in IDLE:
  - 0xA5: load imem.
  - 0x5A: load dmem.
  - 0x0F: RUN. Sets cpu_enable=1 on the next cycle.
  - 0xF0: HALT. Clears cpu_enable on the next cycle.
  - 0xEE: CLR. Clears err.
  - Any other byte: sets err and stays in IDLE.
- Load commands issued while cpu_enable=1: set err, stay in IDLE, perform no memory writes.
- States: IDLE -> LEN0 -> LEN1 -> PAYLOAD <-> WRITE -> IDLE. With the optional feature, the path is ... -> CHK -> IDLE.
  - LEN0 takes N[7:0]; LEN1 takes N[15:8]. N is a 16-bit word count.
  - After LEN1:
    - N==0 -> IDLE.
    - N > IMEM_DEPTH (imem load) or N > DMEM_DEPTH (dmem load) -> err=1, return to IDLE. Payload bytes are not consumed; the sender is responsible for resync.
    - Otherwise -> PAYLOAD, with word index and byte index reset to 0.
- PAYLOAD:
  - Accepts 4 bytes per word (imem) or 8 bytes per word (dmem).
  - Byte k of a word lands in bits [8k+7:8k].
  - On acceptance of the last byte of a word -> WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0.
  - The matching wen=1. Address = word_index*4 (imem) or word_index*8 (dmem). wdata = assembled word.
  - Then word_index increments. If word_index reaches N -> IDLE (or CHK); else -> PAYLOAD.
- Throughput: one byte per cycle, plus one stall cycle per word. Write latency from the last byte's accepting edge is 1 cycle.
- imem_wen and dmem_wen are never both high. Each is high only in WRITE.
- Address and wdata outputs hold their last value outside WRITE. Only wen qualifies them.
- in_ready:
  - 1 in IDLE, LEN0, LEN1, PAYLOAD and CHK.
  - 0 in WRITE.
  - 0 in the cycle after a RUN/HALT/CLR acceptance? No — in_ready stays 1 in that cycle.
- cpu_enable is a register. It changes only on RUN or HALT; it is unaffected by errors.
- rst asserted mid-load: abort immediately. Memory words already written remain. cpu_enable=0.
- A gap in in_valid mid-word or mid-length is allowed. State and partial data are held indefinitely.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHK and accept one byte. That byte must equal the XOR of all payload bytes of this load, with the running XOR reset at LEN1.
  - Mismatch sets err. Memory writes are not undone.
  - CHK -> IDLE.
  - For N==0 the CHK state is skipped.
- Undefined: no CHK state and no XOR register. The last WRITE returns directly to IDLE.

Test Plan:
- Imem load:
  - Stimulus: after rst, send A5 02 00 13 05 10 00 93 05 20 00.
  - Required response: imem_wen pulses twice. First pulse: addr 0x0, data 0x00100513. Second pulse: addr 0x4, data 0x00200593. busy returns to 0. err=0.
- Dmem load with backpressure:
  - Stimulus: send 5A 01 00 EF CD AB 89 67 45 23 01 with in_valid dropped for 3 cycles after the 4th payload byte.
  - Required response: one dmem_wen with addr 0x0, data 0x0123456789ABCDEF. in_ready=0 only during the WRITE cycle.
- Control and protocol errors:
  - 0F -> cpu_enable=1 next cycle.
  - Then A5 -> err=1, no wen, cpu_enable stays 1.
  - F0 -> cpu_enable=0.
  - EE -> err=0.
  - 7B -> err=1.
- Bounds:
  - A5 00 02 (N=512) -> accepted; the 512th write is at addr 0x7FC.
  - A5 01 02 (N=513) -> err=1, state IDLE, no wen.
  - 5A 00 00 -> IDLE immediately, no wen.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle after 2 payload bytes of an imem word, then send A5 01 00 AA BB CC DD.
  - Required response: single write at addr 0x0, data 0xDDCCBBAA. No stale bytes in the word.
- With LOADER_CHECKSUM_EN:
  - A5 01 00 01 02 04 08 0F -> err=0.
  - Same stream with a final byte of 0E -> err=1. The write at addr 0x0 with data 0x08040201 still occurs.
